dense_mac_array: RTL and testbench
==================================

Name: dense_mac_array

Overview:
- Parametrised successor of the single-neuron dense accelerator.
- Computes LANES neurons of a fully-connected layer in parallel from one streamed word bus: out[l] = act(sum_i a_i*w_{i,l} + b_l).
- Uses signed fixed point with FRAC_W fractional bits, a wide accumulator, and an optional ReLU.
- Sits between the HPS/DMA word stream and the result readback registers, with valid/ready handshakes on both sides.

Parameters:
DATA_W, 32, word width of activations, weights, biases and results (signed)
FRAC_W, 24, fractional bits of the fixed-point format (Q8.24 default)
ACC_W, 48, accumulator width per lane, must be >= DATA_W
LANES, 4, number of neurons computed in parallel
LEN_W, 16, width of the length input

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_data  in  DATA_W  streamed activation/weight/bias word
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data this cycle
length  in  LEN_W  number of activations per vector, sampled at vector start
relu_en  in  1  apply ReLU to results, sampled at vector start
out_data  out  LANES*DATA_W  lane l at bits [l*DATA_W +: DATA_W]
out_valid  out  1  out_data holds a completed result set
out_ready  in  1  consumer takes the result set
busy  out  1  a vector is in progress (state != IDLE)

Behaviour:
- Transfer occurs when in_valid && in_ready; the output handshake is out_valid && out_ready. No other event advances the FSM.
- Stream order per vector: a_0, w_{0,0}..w_{0,LANES-1}, a_1, w_{1,0}.., ..., then b_0..b_{LANES-1}.
- States: IDLE, ACT, WEIGHT, BIAS, DONE.
- IDLE: in_ready=1.
  - On transfer: latch length into len_r and relu_en into relu_r; clear all accumulators.
  - If length==0, the word is b_0: add it to lane 0, lane_cnt=1, go to BIAS (or DONE if LANES==1).
  - Otherwise latch it as the activation, elem_cnt=1, lane_cnt=0, go to WEIGHT.
- ACT: in_ready=1. On transfer: latch the activation, elem_cnt++, go to WEIGHT.
- WEIGHT: in_ready=1. On transfer, lane[lane_cnt] += (act*w)>>>FRAC_W.
  - If lane_cnt==LANES-1: lane_cnt=0, then go to BIAS when elem_cnt==len_r, else ACT.
  - Otherwise lane_cnt++.
- BIAS: in_ready=1. On transfer, lane[lane_cnt] += sign-extended bias.
  - After the last lane, register the results and go to DONE.
  - out_valid rises the cycle after the last bias transfer (1-cycle latency).
- DONE: in_ready=0, out_valid=1, out_data stable. When out_ready=1, go to IDLE with out_valid=0 on the next cycle. A new vector cannot start in the same cycle the result is taken.
- Arithmetic:
  - Product is full 2*DATA_W signed, arithmetic-shifted right by FRAC_W (truncates toward -inf), sign-extended to ACC_W.
  - Accumulator wraps modulo 2^ACC_W.
  - Result = relu_r ? max(acc,0) : acc, then saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- length and relu_en changes mid-vector have no effect.
- in_valid low in any state holds state, counters and accumulators.
- Reset, asynchronous and at any time including mid-vector or in DONE:
  - State IDLE; counters, accumulators, relu_r, len_r all 0.
  - Outputs: out_data=0, out_valid=0, busy=0, in_ready=1 after reset deasserts.

Decomposition:
- Package dense_pkg holds the state encoding (IDLE..DONE, 3-bit) plus the default DATA_W/FRAC_W constants and the Q-format ONE constant.
- Sub-module dense_lane, instantiated LANES times, holds:
  - one accumulator with clear and mac_en/bias_en strobes;
  - the multiply/shift;
  - the combinational ReLU and saturation to DATA_W.
- The top holds the FSM, counters, activation register and output register.

Test Plan:
- LANES=4, length=2, relu off, Q8.24.
  - Stimulus: a=1.0, 2.0; w0=0.5,1.0,-1.0,0 and w1=0.25,0.5,1.0,1.0; all biases 1.0.
  - Required: out=0x02000000, 0x03000000, 0x02000000, 0x03000000; out_valid exactly one cycle after the last bias.
- Same vector with relu_en=1, lane 2 bias=-4.0: lane 2 result 0, other lanes unchanged; relu_en toggled mid-vector has no effect.
- Saturation: length=1, a=127.0, w=127.0 on all lanes, bias 0.
  - Required: every lane 0x7FFFFFFF.
  - With w=-127.0: every lane 0x80000000.
- Backpressure: random in_valid gaps, then hold out_ready=0 for 10 cycles.
  - Required: results identical to the gap-free run; in_ready=0 and out_data stable throughout DONE; new vector accepted only after out_ready.
- length=0: four biases 5,6,7,8 (raw) -> out=5,6,7,8.
- Reset pulsed in WEIGHT mid-vector -> out_valid=0 and busy=0 immediately; a following full vector gives the same result as from power-up.

Source files
------------

// File: rtl/dense_pkg.sv
// Shared definitions for the dense MAC array: FSM state encoding and default Q-format constants.
// Q8.24 is the default number format; Q_ONE is 1.0 in that format.
package dense_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACT    = 3'd1,
        ST_WEIGHT = 3'd2,
        ST_BIAS   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_FRAC_W = 24;
    localparam logic [DEF_DATA_W-1:0] Q_ONE = DEF_DATA_W'(1) << DEF_FRAC_W;

endpackage

// File: rtl/dense_lane.sv
// One neuron lane: fixed-point multiply/shift, wrapping accumulator, ReLU and saturation.
// Latency: result is combinational from the accumulator's next value; accumulator updates on the strobe edge.
// Backpressure: none; the lane only moves when the top asserts clear/mac_en/bias_en.
module dense_lane import dense_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int ACC_W  = 48
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              mac_en,
    input  logic              bias_en,
    input  logic [DATA_W-1:0] act,
    input  logic [DATA_W-1:0] word,
    input  logic              relu,
    output logic [DATA_W-1:0] result
);

    // Product width must hold the full 2*DATA_W product and the accumulator width.
    localparam int PW = (2*DATA_W > ACC_W) ? 2*DATA_W : ACC_W;
    localparam logic signed [ACC_W-1:0] SAT_HI =
        $signed((ACC_W'(1) << (DATA_W-1)) - ACC_W'(1));
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    logic signed [ACC_W-1:0] acc, acc_nxt, base, prod_acc, bias_ext, relu_val, sat_val;
    logic signed [PW-1:0]    act_ext, word_ext, prod;

    always_comb begin
        act_ext  = PW'($signed(act));
        word_ext = PW'($signed(word));
        prod     = act_ext * word_ext;
        prod_acc = ACC_W'(prod >>> FRAC_W);
        bias_ext = ACC_W'($signed(word));
        base     = clear ? '0 : acc;
        acc_nxt  = base;
        if (mac_en) begin
            acc_nxt = base + prod_acc;
        end else if (bias_en) begin
            acc_nxt = base + bias_ext;
        end
        relu_val = (relu && (acc_nxt < 0)) ? '0 : acc_nxt;
        if (relu_val > SAT_HI) begin
            sat_val = SAT_HI;
        end else if (relu_val < SAT_LO) begin
            sat_val = SAT_LO;
        end else begin
            sat_val = relu_val;
        end
        result = sat_val[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/dense_mac_array.sv
// LANES-wide fully-connected layer slice fed from one interleaved activation/weight/bias word stream.
// Latency: result set registered on the last bias transfer; out_valid high the following cycle.
// Backpressure: in_ready low only while a result waits in DONE; in_valid gaps hold all state.
module dense_mac_array import dense_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int ACC_W  = 48,
    parameter int LANES  = 4,
    parameter int LEN_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LEN_W-1:0]        length,
    input  logic                    relu_en,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int LC_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_t                  state;
    logic [LEN_W-1:0]        len_r, elem_cnt;
    logic [LC_W-1:0]         lane_cnt, sel;
    logic                    relu_r, relu_cur, xfer, last_lane, clear;
    logic                    mac_stb, bias_stb;
    logic [DATA_W-1:0]       act_r;
    logic [LANES*DATA_W-1:0] lane_res, out_r;

    assign in_ready = (state != ST_DONE);
    assign busy     = (state != ST_IDLE);
    assign out_data = out_r;
    assign xfer     = in_valid && in_ready;

    // A zero-length vector feeds b_0 straight from IDLE, so lane 0 and the live relu_en apply there.
    assign sel       = (state == ST_IDLE) ? '0 : lane_cnt;
    assign last_lane = (sel == LC_W'(LANES-1));
    assign relu_cur  = (state == ST_IDLE) ? relu_en : relu_r;
    assign clear     = xfer && (state == ST_IDLE);
    assign mac_stb   = xfer && (state == ST_WEIGHT);
    assign bias_stb  = xfer && ((state == ST_BIAS) || ((state == ST_IDLE) && (length == '0)));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        dense_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .clear   (clear),
            .mac_en  (mac_stb && (sel == LC_W'(l))),
            .bias_en (bias_stb && (sel == LC_W'(l))),
            .act     (act_r),
            .word    (in_data),
            .relu    (relu_cur),
            .result  (lane_res[l*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            len_r     <= '0;
            elem_cnt  <= '0;
            lane_cnt  <= '0;
            relu_r    <= 1'b0;
            act_r     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (xfer) begin
                    len_r  <= length;
                    relu_r <= relu_en;
                    if (length == '0) begin
                        if (last_lane) begin
                            lane_cnt  <= '0;
                            out_r     <= lane_res;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            lane_cnt <= sel + 1'b1;
                            state    <= ST_BIAS;
                        end
                    end else begin
                        act_r    <= in_data;
                        elem_cnt <= LEN_W'(1);
                        lane_cnt <= '0;
                        state    <= ST_WEIGHT;
                    end
                end
                ST_ACT: if (xfer) begin
                    act_r    <= in_data;
                    elem_cnt <= elem_cnt + 1'b1;
                    state    <= ST_WEIGHT;
                end
                ST_WEIGHT: if (xfer) begin
                    if (last_lane) begin
                        lane_cnt <= '0;
                        state    <= (elem_cnt == len_r) ? ST_BIAS : ST_ACT;
                    end else begin
                        lane_cnt <= sel + 1'b1;
                    end
                end
                ST_BIAS: if (xfer) begin
                    if (last_lane) begin
                        lane_cnt  <= '0;
                        out_r     <= lane_res;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        lane_cnt <= sel + 1'b1;
                    end
                end
                ST_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_mac_array.sv
// Randomised and directed checks of dense_mac_array against an arithmetic reference of the layer equation.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_dense_mac_array;

    localparam int DW = 32;
    localparam int NL = 4;
    localparam logic [31:0] ONE = 32'h0100_0000;

    logic            clk;
    logic            reset;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     length;
    logic            relu_en;
    logic [NL*DW-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] va [8];
    logic [31:0] vw [8][NL];
    logic [31:0] vb [NL];

    dense_mac_array #(
        .DATA_W (32), .FRAC_W (24), .ACC_W (48), .LANES (NL), .LEN_W (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .length    (length),
        .relu_en   (relu_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: sum of truncated Q-format products plus bias, wrapped to 48 bits, ReLU, then saturated.
    function automatic logic [31:0] model_lane(input int l, input int len, input bit relu);
        longint acc = 0;
        longint p;
        for (int i = 0; i < len; i++) begin
            p = longint'($signed(va[i])) * longint'($signed(vw[i][l]));
            acc += (p >>> 24);
        end
        acc += longint'($signed(vb[l]));
        acc = (acc <<< 16) >>> 16;
        if (relu && acc < 0) acc = 0;
        if (acc > 64'sh7FFF_FFFF) acc = 64'sh7FFF_FFFF;
        else if (acc < -64'sh8000_0000) acc = -64'sh8000_0000;
        return acc[31:0];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input int gap);
        int t = 0;
        in_valid = 1'b0;
        repeat (gap) cyc();
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            cyc();
            t++;
        end
        if (t >= 200) chk("in_ready_timeout", 0, 1);
        cyc();
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic run_vector(input string tag, input int len, input bit relu, input bit relu_mid,
                              input int gap, input int hold, output logic [NL*DW-1:0] res);
        logic [31:0] q[$];
        logic [NL*DW-1:0] snap;
        bit stable = 1;
        bit blocked = 1;
        for (int i = 0; i < len; i++) begin
            q.push_back(va[i]);
            for (int l = 0; l < NL; l++) q.push_back(vw[i][l]);
        end
        for (int l = 0; l < NL; l++) q.push_back(vb[l]);
        length  = 16'(len);
        relu_en = relu;
        for (int k = 0; k < q.size(); k++) begin
            if (k == q.size() - 1) chk({tag, "_pre_valid"}, out_valid, 0);
            send_word(q[k], (gap > 0) ? $urandom_range(0, gap) : 0);
            if (k == 0) begin
                relu_en = relu_mid;
                length  = 16'($urandom);
            end
        end
        chk({tag, "_valid_lat"}, out_valid, 1);
        for (int l = 0; l < NL; l++)
            chk({tag, "_lane"}, out_data[l*DW +: DW], model_lane(l, len, relu));
        res  = out_data;
        snap = out_data;
        in_valid = 1'b1;
        in_data  = $urandom;
        for (int h = 0; h < hold; h++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b1) blocked = 0;
            if (out_data !== snap) stable = 0;
            cyc();
        end
        if (hold > 0) begin
            chk({tag, "_done_blocked"}, blocked, 1);
            chk({tag, "_done_stable"}, stable, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk({tag, "_released"}, {out_valid, busy, in_ready}, 3'b001);
    endtask

    task automatic load_base(input logic [31:0] b2);
        va[0] = ONE;      va[1] = ONE << 1;
        vw[0][0] = ONE >> 1; vw[0][1] = ONE; vw[0][2] = -ONE;    vw[0][3] = 32'h0;
        vw[1][0] = ONE >> 2; vw[1][1] = ONE >> 1; vw[1][2] = ONE; vw[1][3] = ONE;
        vb[0] = ONE; vb[1] = ONE; vb[2] = b2; vb[3] = ONE;
    endtask

    function automatic logic [31:0] rnd_word();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'($urandom_range(0, 32'h0800_0000)) - 32'h0400_0000;
    endfunction

    logic [NL*DW-1:0] res, ref_res;

    initial begin
        reset = 1'b0; in_data = '0; in_valid = 1'b0; length = '0; relu_en = 1'b0; out_ready = 1'b0;
        #23;
        chk("reset_state", {out_valid, busy, in_ready}, 3'b001);
        chk("reset_out_data", out_data, '0);
        reset = 1'b1;
        cyc();

        load_base(ONE);
        run_vector("basic", 2, 0, 0, 0, 0, ref_res);
        chk("basic_const", ref_res, {32'h0300_0000, 32'h0200_0000, 32'h0300_0000, 32'h0200_0000});

        load_base(-(ONE << 2));
        run_vector("relu", 2, 1, 0, 0, 3, res);
        chk("relu_const", res, {32'h0300_0000, 32'h0000_0000, 32'h0300_0000, 32'h0200_0000});

        va[0] = 32'd127 << 24;
        for (int l = 0; l < NL; l++) begin vw[0][l] = 32'd127 << 24; vb[l] = 0; end
        run_vector("sat_pos", 1, 0, 1, 0, 0, res);
        chk("sat_pos_const", res, {4{32'h7FFF_FFFF}});
        for (int l = 0; l < NL; l++) vw[0][l] = -(32'd127 << 24);
        run_vector("sat_neg", 1, 0, 0, 0, 0, res);
        chk("sat_neg_const", res, {4{32'h8000_0000}});

        load_base(ONE);
        run_vector("gaps", 2, 0, 1, 4, 10, res);
        chk("gaps_same", res, ref_res);

        for (int l = 0; l < NL; l++) vb[l] = 32'(l + 5);
        run_vector("len0", 0, 0, 0, 2, 2, res);
        chk("len0_const", res, {32'd8, 32'd7, 32'd6, 32'd5});

        load_base(ONE);
        length = 16'd2; relu_en = 1'b0;
        send_word(va[0], 0);
        send_word(vw[0][0], 0);
        send_word(vw[0][1], 0);
        #2 reset = 1'b0;
        #1;
        chk("midreset_state", {out_valid, busy}, 2'b00);
        #2 reset = 1'b1;
        cyc();
        chk("midreset_ready", in_ready, 1);
        run_vector("after_reset", 2, 0, 0, 0, 0, res);
        chk("after_reset_same", res, ref_res);

        for (int it = 0; it < 20; it++) begin
            int len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                va[i] = rnd_word();
                for (int l = 0; l < NL; l++) vw[i][l] = rnd_word();
            end
            for (int l = 0; l < NL; l++) vb[l] = rnd_word();
            run_vector("rand", len, 1'($urandom), 1'($urandom), $urandom_range(0, 3),
                       $urandom_range(0, 4), res);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        chk("global_timeout", 0, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "simulation time limit reached");
    end

endmodule
